// File: rtl/program_sequencer_stack.sv
// Program sequencer: generates the next program-memory address each cycle,
// with jumps, a return-address stack for call/ret, fetch hold and sticky stack-error flags.
module program_sequencer_stack #(
    parameter int unsigned PC_WIDTH       = 8,
    parameter int unsigned JMP_ADDR_WIDTH = 4,
    parameter int unsigned STACK_DEPTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 sync_reset_n,
    input  logic                                 jmp,
    input  logic                                 jmp_nz,
    input  logic                                 dont_jmp,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic                                 hold,
    input  logic [JMP_ADDR_WIDTH-1:0]            jmp_addr,
    output logic [PC_WIDTH-1:0]                  pm_addr,
    output logic [PC_WIDTH-1:0]                  pc,
    output logic [PC_WIDTH-1:0]                  from_PS,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 stack_overflow,
    output logic                                 stack_underflow
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                stack_overflow_q, stack_overflow_d;
    logic                stack_underflow_q, stack_underflow_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] top;
    logic                stack_empty;
    logic                stack_full;

    // Jump targets address page boundaries: the field lands in the top bits.
    assign target      = PC_WIDTH'(jmp_addr) << (PC_WIDTH - JMP_ADDR_WIDTH);
    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));

    // Top-of-stack as a one-hot match on sp; stays 0 when the stack is empty.
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) top = stack_q[i];
        end
    end

    always_comb begin
        if (!sync_reset_n)                        pm_addr = '0;
        else if (hold)                            pm_addr = pc_q;
        else if (ret)                             pm_addr = stack_empty ? pc_inc : top;
        else if (call || jmp || (jmp_nz && !dont_jmp)) pm_addr = target;
        else                                      pm_addr = pc_inc;
    end

    assign pc_d = pm_addr;

    always_comb begin
        sp_d              = sp_q;
        stack_overflow_d  = stack_overflow_q;
        stack_underflow_d = stack_underflow_q;
        stack_d           = stack_q;
        if (sync_reset_n && !hold) begin
            if (ret) begin
                if (stack_empty) stack_underflow_d = 1'b1;
                else             sp_d = sp_q - SP_W'(1);
            end else if (call) begin
                if (stack_full) begin
                    stack_overflow_d = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                        if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
                    end
                    sp_d = sp_q + SP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            pc_q              <= '0;
            sp_q              <= '0;
            stack_overflow_q  <= 1'b0;
            stack_underflow_q <= 1'b0;
        end else begin
            pc_q              <= pc_d;
            sp_q              <= sp_d;
            stack_overflow_q  <= stack_overflow_d;
            stack_underflow_q <= stack_underflow_d;
        end
    end

    // Entries are never visible past sp, so they need no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc              = pc_q;
    assign sp              = sp_q;
    assign from_PS         = top;
    assign stack_overflow  = stack_overflow_q;
    assign stack_underflow = stack_underflow_q;

endmodule

// File: doc/program_sequencer_stack.md
Name: program_sequencer_stack

Overview:
Parametrised next-generation program sequencer for the microprocessor core. It generates the program-memory address each cycle and adds four things the current sequencer lacks: configurable PC and jump-target widths, a subroutine call/return stack of configurable depth, a fetch-hold (stall) input, and sticky stack-error flags. It sits between the instruction decoder (control inputs) and program memory (pm_addr), replacing the fixed 8-bit sequencer.

Parameters:
PC_WIDTH, 8, width of pc, pm_addr and the return-address stack entries.
JMP_ADDR_WIDTH, 4, width of the jump-target field from the instruction register; must be ≤ PC_WIDTH.
STACK_DEPTH, 4, number of return-address entries; must be ≥1.

Ports:
clk  input  1  system clock, all state updates on the rising edge.
sync_reset_n  input  1  synchronous, active-low reset.
jmp  input  1  unconditional jump.
jmp_nz  input  1  conditional jump, taken when dont_jmp=0.
dont_jmp  input  1  zero flag from the computational unit.
call  input  1  subroutine call: push return address, then jump.
ret  input  1  return: pop the stack into the PC.
hold  input  1  stall: re-present the current pc, no state change.
jmp_addr  input  JMP_ADDR_WIDTH  jump/call target field.
pm_addr  output  PC_WIDTH  next program-memory address (combinational).
pc  output  PC_WIDTH  registered program counter.
from_PS  output  PC_WIDTH  debug: current top-of-stack, 0 when the stack is empty.
sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
stack_overflow  output  1  sticky; set by a call made while the stack is full.
stack_underflow  output  1  sticky; set by a ret made while the stack is empty.

Behaviour:
- target = jmp_addr << (PC_WIDTH-JMP_ADDR_WIDTH). The low bits are zero-filled, matching the current {nibble,4'h0} page-jump convention at the defaults.
- pm_addr is combinational. It is selected by the first matching condition in this order:
  1. sync_reset_n=0 → 0.
  2. hold → pc.
  3. ret with sp>0 → stack[sp-1]; ret with sp=0 → pc+1.
  4. call → target.
  5. jmp → target.
  6. jmp_nz & ~dont_jmp → target.
  7. Otherwise → pc+1.
- pc+1 is modulo 2^PC_WIDTH: the all-ones value wraps to 0, with no flag.
- Every rising edge with sync_reset_n=1 loads pc ← pm_addr. An instruction fetched at pm_addr executes one cycle later, so there is no added latency versus the current sequencer.
- Stack update, only when not in reset and not on hold:
  - call with sp<STACK_DEPTH: stack[sp] ← pc+1 (wrapped), sp ← sp+1.
  - call with sp=STACK_DEPTH: no push, the jump is still taken, stack_overflow ← 1.
  - ret with sp>0: sp ← sp-1.
  - ret with sp=0: stack_underflow ← 1, and execution falls through as a NOP.
- Lower-priority inputs asserted together with a higher-priority one are ignored. For example, call+ret → ret wins and no push occurs.
- hold=1 with any other input: no change to pc, sp, stack contents or flags.
- Reset (sync_reset_n=0 at an edge): pc=0, sp=0, both flags=0. Stack contents are don't-care but are never visible, because from_PS=0 while sp=0.
- Reset asserted mid-call or mid-return aborts the operation; no push or pop is committed.
- from_PS = stack[sp-1] when sp>0, else 0.
- Flags stay set until reset; there is no other clear.
- The memory clocks on ~clk, as at present, and sees pm_addr stable for the half cycle.

Test Plan:
1. Reset then run (defaults): hold sync_reset_n=0 for 2 cycles, then release with no controls → pm_addr=0 during reset, then pc steps 0,1,2…; it wraps from 0xFF to 0x00 after 256 cycles with no flag.
2. Jumps: at pc=0x05 assert jmp with jmp_addr=4'hA → pm_addr=0xA0 and next pc=0xA0. Then jmp_nz with dont_jmp=1 → pc=0xA1; jmp_nz with dont_jmp=0 and jmp_addr=3 → pc=0x30.
3. Nested call/return: call to 0x20 at pc=0x07 → sp=1, from_PS=0x08. Then call to 0x40 at pc=0x21 → sp=2, from_PS=0x22. Then ret → pc=0x22; then ret → pc=0x08, sp=0, from_PS=0.
4. Overflow/underflow with STACK_DEPTH=2: three successive calls → third still jumps, sp=2, stack_overflow=1. Two rets return correctly; a third ret → pc+1, stack_underflow=1; both flags persist until reset.
5. Hold and simultaneous events: hold with call asserted → pc, sp and flags unchanged for all hold cycles. call+ret with sp=1 → pops, no push. Reset asserted in the call cycle → pc=0, sp=0.
6. Parametrisation: PC_WIDTH=10, JMP_ADDR_WIDTH=6, jmp_addr=6'h3F → pm_addr=10'h3F0; wrap from 0x3FF to 0x000.
